// File: rtl/dec_seq_pkg.sv
// Shared constants and helpers for the one-hot sequencing decoder.
// onehot() is sized for the widest supported position; callers truncate.
package dec_seq_pkg;

  localparam logic [1:0] MODE_DECODE    = 2'b00;
  localparam logic [1:0] MODE_RING_UP   = 2'b01;
  localparam logic [1:0] MODE_RING_DOWN = 2'b10;
  localparam logic [1:0] MODE_BOUNCE    = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MAX_IN_W  = 8;
  localparam int MAX_OUT_W = 2 ** MAX_IN_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] p);
    logic [MAX_OUT_W-1:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_onehot_seq_dwell_tick.sv
// Dwell counter: step asserts once cnt has reached dwell, so each position
// is held dwell+1 counted cycles. clr restarts the hold from zero.
module dwell_tick #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] cnt;

  // A dwell lowered below the running count forces an immediate step.
  assign step = (cnt >= dwell);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (step) cnt <= '0;
      else      cnt <= cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered N-to-2^N one-hot decoder with ring-up, ring-down and bounce
// sequencing at a programmable dwell rate.
module dec_onehot_seq
  import dec_seq_pkg::*;
#(
  parameter  int IN_W    = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** IN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [IN_W-1:0]    in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [IN_W-1:0]    pos,
  output logic               wrap
);

  localparam logic [IN_W-1:0] POS_MAX = '1;

  logic [IN_W-1:0]  pos_n;
  logic [OUT_W-1:0] out_n;
  logic             dir, dir_n;
  logic             wrap_n;
  logic             clr;
  logic             step;
  logic             en_q;
  logic [1:0]       mode_q;
  logic             mode_vld;
  logic             mode_chg;

  // en_q low marks the first edge after re-enable: show held pos, no step.
  dwell_tick #(.DWELL_W(DWELL_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en & en_q),
    .clr   (clr),
    .dwell (dwell),
    .step  (step)
  );

  assign mode_chg = mode_vld && (mode != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      dir      <= DIR_UP;
      out      <= '0;
      wrap     <= 1'b0;
      en_q     <= 1'b1;
      mode_q   <= MODE_DECODE;
      mode_vld <= 1'b0;
    end else begin
      pos  <= pos_n;
      dir  <= dir_n;
      out  <= out_n;
      wrap <= wrap_n;
      en_q <= en;
      if (en) begin
        mode_q   <= mode;
        mode_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    pos_n  = pos;
    dir_n  = dir;
    wrap_n = 1'b0;
    clr    = 1'b0;
    if (en) begin
      if (mode == MODE_DECODE) begin
        pos_n = in;
        dir_n = DIR_UP;
        clr   = 1'b1;
      end else if (load) begin
        pos_n = in;
        dir_n = (in == POS_MAX) ? DIR_DOWN : DIR_UP;
        clr   = 1'b1;
      end else if (mode_chg) begin
        clr = 1'b1;
        if (mode == MODE_BOUNCE) dir_n = (pos == POS_MAX) ? DIR_DOWN : DIR_UP;
      end else if (en_q && step) begin
        case (mode)
          MODE_RING_UP: begin
            pos_n  = pos + IN_W'(1);
            wrap_n = (pos == POS_MAX);
          end
          MODE_RING_DOWN: begin
            pos_n  = pos - IN_W'(1);
            wrap_n = (pos == '0);
          end
          MODE_BOUNCE: begin
            if (dir == DIR_UP) begin
              pos_n = pos + IN_W'(1);
              if (pos_n == POS_MAX) dir_n = DIR_DOWN;
            end else begin
              pos_n = pos - IN_W'(1);
              if (pos_n == '0) begin
                dir_n  = DIR_UP;
                wrap_n = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    out_n = '0;
    if (en) out_n = OUT_W'(onehot(MAX_IN_W'(pos_n)));
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Randomised and directed bench for dec_onehot_seq with a queue scoreboard
// fed by a position/phase reference model.
module tb_dec_onehot_seq;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] pos;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] in_s;
  logic       load;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] pos;
  logic       wrap;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: position, cycles held, bounce phase over a 2N-2 period.
  int m_pos, m_age, m_phase, m_mode;
  bit m_seen, m_en_prev;

  dec_onehot_seq #(.IN_W(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in_s),
    .load  (load),
    .dwell (dwell),
    .out   (out),
    .pos   (pos),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_age = 0; m_phase = 0; m_mode = 0;
    m_seen = 1'b0; m_en_prev = 1'b1;
  endtask

  task automatic apply(input bit e, input int md, input int i, input bit ld, input int dw);
    bit   w, chg, resume;
    exp_t x;
    en = e; mode = md[1:0]; in_s = i[2:0]; load = ld; dwell = dw[7:0];
    w = 1'b0;
    if (e) begin
      chg    = m_seen && (md != m_mode);
      resume = !m_en_prev;
      m_seen = 1'b1;
      m_mode = md;
      if (md == 0) begin
        m_pos = i; m_age = 0;
      end else if (ld) begin
        m_pos = i; m_age = 0; m_phase = i;
      end else if (chg) begin
        m_age = 0; m_phase = m_pos;
      end else if (resume) begin
        // held position shown again, count frozen
      end else if (m_age >= dw) begin
        m_age = 0;
        case (md)
          1: begin w = (m_pos == N-1); m_pos = (m_pos + 1) % N; end
          2: begin w = (m_pos == 0);   m_pos = (m_pos + N - 1) % N; end
          default: begin
            m_phase = (m_phase + 1) % (2*N - 2);
            m_pos   = (m_phase < N) ? m_phase : (2*N - 2 - m_phase);
            w       = (m_pos == 0);
          end
        endcase
      end else begin
        m_age++;
      end
    end
    m_en_prev = e;
    x.out  = e ? 8'(1 << m_pos) : 8'h00;
    x.pos  = 3'(m_pos);
    x.wrap = w;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit e, input int md, input int i, input bit ld, input int dw);
    @(negedge clk);
    apply(e, md, i, ld, dw);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",  32'(out),  32'(e.out));
        chk("pos",  32'(pos),  32'(e.pos));
        chk("wrap", 32'(wrap), 32'(e.wrap));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int md, dw;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; in_s = '0; load = 1'b0; dwell = '0;
    model_reset();
    #2;
    chk("reset_out",  32'(out),  32'h0);
    chk("reset_pos",  32'(pos),  32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < N; i++) cyc(1, 0, i, 0, 0);
    cyc(0, 0, 3, 0, 0);

    // ring up, dwell 2, from 6
    cyc(1, 1, 6, 1, 2);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 2);

    // ring down, dwell 0, from 1, then freeze and resume
    cyc(1, 2, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 2, 0, 0, 0);

    // bounce from 0
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 3, 0, 0, 0);

    // load priority over step, and load ignored while disabled
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 5, 1, 0);
    cyc(0, 1, 2, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);

    // async reset while pos=4, then a full dwell at 0
    cyc(1, 1, 4, 1, 2);
    cyc(1, 1, 0, 0, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_out",  32'(out),  32'h0);
    chk("areset_pos",  32'(pos),  32'h0);
    chk("areset_wrap", 32'(wrap), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    apply(1, 1, 0, 0, 2);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 2);

    md = 1; dw = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) dw = $urandom_range(0, 4);
      cyc($urandom_range(0, 9) != 0, md, $urandom_range(0, 7),
          $urandom_range(0, 9) == 0, dw);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
